// File: rtl/spu_sm_exp_sum.sv
// Softmax exponent-and-sum stage: per-lane e = 0xFF >> min((max - x) >> 2, 8)
// through a two-stage pipeline, with a saturating row accumulator.
module spu_sm_exp_sum #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 18
) (
    input  logic                     core_clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] max_in,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] x0,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    output logic                     in_ready,
    output logic        [DATA_W-1:0] e0,
    output logic        [DATA_W-1:0] e1,
    output logic        [DATA_W-1:0] e2,
    output logic        [DATA_W-1:0] e3,
    output logic                     out_valid,
    output logic        [SUM_W-1:0]  sum_out,
    output logic                     sum_valid,
    output logic                     busy
);

    localparam int              K_W   = $clog2(DATA_W + 1);
    localparam logic [K_W-1:0]  K_MAX = K_W'(DATA_W);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [K_W-1:0] calc_k(input logic signed [DATA_W-1:0] m,
                                              input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W:0] diff;
        logic        [DATA_W:0] shr;
        diff = (DATA_W+1)'(m) - (DATA_W+1)'(x);
        if (diff[DATA_W]) shr = '0;
        else              shr = $unsigned(diff) >> 2;
        if (shr > (DATA_W+1)'(K_MAX)) calc_k = K_MAX;
        else                          calc_k = shr[K_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] exp_approx(input logic [K_W-1:0] k);
        exp_approx = {DATA_W{1'b1}} >> k;
    endfunction

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        sat_add = s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
    endfunction

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic signed [DATA_W-1:0]   r_max;
    logic                       w_xfer;
    logic signed [DATA_W-1:0]   w_x [4];
    logic        [K_W-1:0]      r_k_p1 [4];
    logic                       r_vld_p1;
    logic        [DATA_W-1:0]   w_e_p1 [4];
    logic        [SUM_W-1:0]    w_lane_sum;
    logic        [DATA_W-1:0]   r_e_p2 [4];
    logic                       r_vld_p2;
    logic        [SUM_W-1:0]    r_acc;
    logic                       r_sum_vld;

    assign w_x[0] = x0;
    assign w_x[1] = x1;
    assign w_x[2] = x2;
    assign w_x[3] = x3;

    assign in_ready = (r_state == RUN);
    assign busy     = (r_state != IDLE);
    assign w_xfer   = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_xfer && in_last) w_state_nxt = DRAIN;
            DRAIN:   if (r_vld_p1) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_max   <= 8'sh81;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && start) r_max <= max_in;
        end
    end

    // Stage 1: clamped shift amount per lane
    always_ff @(posedge core_clk) begin
        if (w_xfer) begin
            for (int i = 0; i < 4; i++) r_k_p1[i] <= calc_k(r_max, w_x[i]);
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) r_vld_p1 <= 1'b0;
        else        r_vld_p1 <= w_xfer;
    end

    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < 4; i++) begin
            w_e_p1[i]  = exp_approx(r_k_p1[i]);
            w_lane_sum = w_lane_sum + SUM_W'(w_e_p1[i]);
        end
    end

    // Stage 2: exponent lanes and accumulation on the same edge
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_e_p2[i] <= '0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                for (int i = 0; i < 4; i++) r_e_p2[i] <= w_e_p1[i];
            end
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_sum_vld <= 1'b0;
        end else begin
            r_sum_vld <= (r_state == DONE);
            if (r_state == IDLE && start) r_acc <= '0;
            else if (r_vld_p1)            r_acc <= sat_add(r_acc, w_lane_sum);
        end
    end

    assign e0        = r_e_p2[0];
    assign e1        = r_e_p2[1];
    assign e2        = r_e_p2[2];
    assign e3        = r_e_p2[3];
    assign out_valid = r_vld_p2;
    assign sum_out   = r_acc;
    assign sum_valid = r_sum_vld;

endmodule

// File: tb/tb_spu_sm_exp_sum.sv
// Directed bench for spu_sm_exp_sum: single beats, clamping, streaming,
// saturation, gaps/backpressure and mid-row reset.
module tb_spu_sm_exp_sum;

    logic              core_clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic signed [7:0] max_in;
    logic              in_valid;
    logic              in_last;
    logic signed [7:0] x0, x1, x2, x3;
    logic              in_ready;
    logic [7:0]        e0, e1, e2, e3;
    logic              out_valid;
    logic [17:0]       sum_out;
    logic              sum_valid;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    spu_sm_exp_sum dut (
        .core_clk (core_clk),
        .rst_n    (rst_n),
        .start    (start),
        .max_in   (max_in),
        .in_valid (in_valid),
        .in_last  (in_last),
        .x0       (x0),
        .x1       (x1),
        .x2       (x2),
        .x3       (x3),
        .in_ready (in_ready),
        .e0       (e0),
        .e1       (e1),
        .e2       (e2),
        .e3       (e3),
        .out_valid(out_valid),
        .sum_out  (sum_out),
        .sum_valid(sum_valid),
        .busy     (busy)
    );

    always #5 core_clk = ~core_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(negedge core_clk);
    endtask

    task automatic beat(input logic signed [7:0] a, input logic signed [7:0] b,
                        input logic signed [7:0] c, input logic signed [7:0] d,
                        input logic last);
        in_valid = 1'b1;
        in_last  = last;
        x0 = a; x1 = b; x2 = c; x3 = d;
    endtask

    task automatic stream_row(input int n, output int ov_cnt, output int max_run,
                              output int sv_cnt, output logic [17:0] sum_cap);
        int run;
        ov_cnt = 0; max_run = 0; sv_cnt = 0; sum_cap = '0; run = 0;
        start = 1'b1; max_in = 8'sd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < n + 6; i++) begin
            if (i < n) beat(8'sd0, 8'sd0, 8'sd0, 8'sd0, (i == n - 1));
            else       in_valid = 1'b0;
            tick();
            if (out_valid) begin
                ov_cnt++; run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (sum_valid) begin
                sv_cnt++; sum_cap = sum_out;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; max_in = 8'sd0; in_valid = 1'b0; in_last = 1'b0;
        x0 = 8'sd0; x1 = 8'sd0; x2 = 8'sd0; x3 = 8'sd0;
        #2 rst_n = 1'b0;
        tick();
        checks++; if ({in_ready, busy, out_valid, sum_valid} !== 4'b0) begin failures++; $display("FAIL reset_flags: got %b required 0000", {in_ready, busy, out_valid, sum_valid}); end
        checks++; if ({e0, e1, e2, e3} !== 32'h0) begin failures++; $display("FAIL reset_e: got %h required 0", {e0, e1, e2, e3}); end
        checks++; if (sum_out !== 18'd0) begin failures++; $display("FAIL reset_sum: got %0d required 0", sum_out); end
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_single_beat();
        start = 1'b1; max_in = 8'sd10;
        tick();
        start = 1'b0;
        checks++; if ({in_ready, busy} !== 2'b11) begin failures++; $display("FAIL sb_run: got %b required 11", {in_ready, busy}); end
        beat(8'sd10, 8'sd9, 8'sd2, -8'sd118, 1'b1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b00) begin failures++; $display("FAIL sb_drain: got %b required 00", {in_ready, out_valid}); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sb_out_valid: got %b required 1", out_valid); end
        checks++; if ({e0, e1, e2, e3} !== {8'd255, 8'd255, 8'd63, 8'd0}) begin failures++; $display("FAIL sb_e: got %0d %0d %0d %0d required 255 255 63 0", e0, e1, e2, e3); end
        checks++; if (sum_valid !== 1'b0) begin failures++; $display("FAIL sb_sum_early: got %b required 0", sum_valid); end
        tick();
        checks++; if (sum_valid !== 1'b1 || sum_out !== 18'd573) begin failures++; $display("FAIL sb_sum: got valid=%b sum=%0d required valid=1 sum=573", sum_valid, sum_out); end
        checks++; if ({busy, out_valid} !== 2'b00) begin failures++; $display("FAIL sb_idle: got %b required 00", {busy, out_valid}); end
        tick();
        checks++; if (sum_valid !== 1'b0 || sum_out !== 18'd573) begin failures++; $display("FAIL sb_hold: got valid=%b sum=%0d required valid=0 sum=573", sum_valid, sum_out); end
    endtask

    task automatic test_clamp();
        start = 1'b1; max_in = -8'sd5;
        tick();
        start = 1'b0;
        beat(8'sd20, -8'sd5, -8'sd6, -8'sd9, 1'b1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        checks++; if ({e0, e1, e2, e3} !== {8'd255, 8'd255, 8'd255, 8'd127}) begin failures++; $display("FAIL clamp_e: got %0d %0d %0d %0d required 255 255 255 127", e0, e1, e2, e3); end
        tick();
        checks++; if (sum_valid !== 1'b1 || sum_out !== 18'd892) begin failures++; $display("FAIL clamp_sum: got valid=%b sum=%0d required valid=1 sum=892", sum_valid, sum_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        int ov, mr, sv;
        logic [17:0] s;
        stream_row(256, ov, mr, sv, s);
        checks++; if (ov !== 256) begin failures++; $display("FAIL b2b_ov_count: got %0d required 256", ov); end
        checks++; if (mr !== 256) begin failures++; $display("FAIL b2b_ov_run: got %0d required 256", mr); end
        checks++; if (sv !== 1) begin failures++; $display("FAIL b2b_sum_valid_count: got %0d required 1", sv); end
        checks++; if (s !== 18'd261120) begin failures++; $display("FAIL b2b_sum: got %0d required 261120", s); end
    endtask

    task automatic test_saturation();
        int ov, mr, sv;
        logic [17:0] s;
        stream_row(258, ov, mr, sv, s);
        checks++; if (s !== 18'h3FFFF) begin failures++; $display("FAIL sat_sum: got %0d required 262143", s); end
        checks++; if (sv !== 1) begin failures++; $display("FAIL sat_sum_valid_count: got %0d required 1", sv); end
    endtask

    task automatic test_gaps();
        logic [3:0] ovp;
        start = 1'b1; max_in = 8'sd0;
        tick();
        start = 1'b0;
        beat(8'sd0, 8'sd0, 8'sd0, 8'sd0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        ovp[3] = out_valid;
        beat(8'sd0, 8'sd0, 8'sd0, 8'sd0, 1'b1);
        tick();
        ovp[2] = out_valid;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL gap_drain_ready: got %b required 0", in_ready); end
        // beat offered and start pulsed while draining
        beat(-8'sd128, -8'sd128, -8'sd128, -8'sd128, 1'b1);
        start = 1'b1; max_in = 8'sd50;
        tick();
        ovp[1] = out_valid;
        tick();
        ovp[0] = out_valid;
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        checks++; if (ovp !== 4'b1010) begin failures++; $display("FAIL gap_ov_pattern: got %b required 1010", ovp); end
        checks++; if (sum_valid !== 1'b1 || sum_out !== 18'd2040) begin failures++; $display("FAIL gap_sum: got valid=%b sum=%0d required valid=1 sum=2040", sum_valid, sum_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gap_start_ignored: busy=%b required 0", busy); end
        tick();
    endtask

    task automatic test_reset_mid_row();
        int sv;
        start = 1'b1; max_in = 8'sd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(8'sd0, 8'sd0, 8'sd0, 8'sd0, 1'b0);
            tick();
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if ({in_ready, busy, out_valid, sum_valid} !== 4'b0) begin failures++; $display("FAIL rmr_flags: got %b required 0000", {in_ready, busy, out_valid, sum_valid}); end
        checks++; if ({e0, e1, e2, e3} !== 32'h0 || sum_out !== 18'd0) begin failures++; $display("FAIL rmr_data: got e=%h sum=%0d required 0", {e0, e1, e2, e3}, sum_out); end
        tick();
        tick();
        rst_n = 1'b1;
        sv = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sum_valid || busy) sv++;
        end
        checks++; if (sv !== 0) begin failures++; $display("FAIL rmr_quiet: got %0d active cycles required 0", sv); end
        start = 1'b1; max_in = 8'sd1;
        tick();
        start = 1'b0;
        beat(8'sd1, 8'sd1, 8'sd1, 8'sd1, 1'b1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        tick();
        checks++; if (sum_valid !== 1'b1 || sum_out !== 18'd1020) begin failures++; $display("FAIL rmr_new_row: got valid=%b sum=%0d required valid=1 sum=1020", sum_valid, sum_out); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_clamp();
        test_back_to_back();
        test_saturation();
        test_gaps();
        test_reset_mid_row();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
